// File: rtl/capture_ctrl_pkg.sv
// Shared types and bit positions for the capture controller.
// Register map: ctrl (reg 0), len (reg 1), div (reg 2), status (reg 3).
package capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_IRQ_CLR = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;
  localparam int STAT_ERR     = 3;
  localparam int STAT_IRQ     = 4;
  localparam int STAT_CNT_LSB = 16;
  localparam int STAT_CNT_W   = 16;

endpackage

// File: rtl/capture_strobe_gen.sv
// Sample-strobe divider: counts 0..div-1 while enabled and pulses on div-1.
// The counter is held at zero whenever enable is low.
module capture_strobe_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt_r;
  logic             last_s;

  assign last_s = (cnt_r == (div - DIV_W'(1)));
  assign strobe = enable & last_s;

  // Divider counter, wraps after the strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (!enable || last_s) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Microphone capture frame controller: start/abort handling, sample counting and status.
// Optional interrupt logic is built when CAPTURE_CTRL_IRQ_EN is defined.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int DIV_W = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] ctrl_reg,
  input  logic [31:0] len_reg,
  input  logic [31:0] div_reg,
  output logic [31:0] status_reg,
  output logic        smp_strobe,
  output logic        frame_start,
  output logic        frame_end,
  output logic        busy
`ifdef CAPTURE_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  state_t           state_r, state_s;
  logic             start_prev_r;
  logic [LEN_W-1:0] len_r;
  logic [DIV_W-1:0] div_r;
  logic [LEN_W-1:0] count_r;
  logic             done_r, aborted_r, err_r, frame_start_r;
  logic             start_evt_s, start_ok_s, start_bad_s, abort_s;
  logic             gen_strobe_s, run_s, irq_bit_s;
  logic [STAT_CNT_W-1:0] cnt_field_s;

  assign start_evt_s = ctrl_reg[CTRL_START] & ~start_prev_r;
  assign run_s       = (state_r == ST_RUN);

  capture_strobe_gen #(.DIV_W(DIV_W)) u_strobe_gen (
    .clk    (ACLK),
    .rst    (ARESET),
    .enable (run_s),
    .div    (div_r),
    .strobe (gen_strobe_s)
  );

  // Next state; abort outranks a coincident final strobe.
  always_comb begin
    state_s     = state_r;
    start_ok_s  = 1'b0;
    start_bad_s = 1'b0;
    abort_s     = 1'b0;
    smp_strobe  = 1'b0;
    frame_end   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_evt_s) begin
          if ((len_reg[LEN_W-1:0] != {LEN_W{1'b0}}) && (div_reg[DIV_W-1:0] != {DIV_W{1'b0}})) begin
            start_ok_s = 1'b1;
            state_s    = ST_RUN;
          end else begin
            start_bad_s = 1'b1;
            state_s     = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ctrl_reg[CTRL_ABORT]) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else if (gen_strobe_s) begin
          smp_strobe = 1'b1;
          if ((count_r + LEN_W'(1)) == len_r) begin
            frame_end = 1'b1;
            state_s   = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, start-edge history and frame_start pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r       <= ST_IDLE;
      start_prev_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      start_prev_r  <= ctrl_reg[CTRL_START];
      frame_start_r <= start_ok_s;
    end
  end

  // Frame parameters, sample count and sticky status flags.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      len_r     <= {LEN_W{1'b0}};
      div_r     <= {DIV_W{1'b0}};
      count_r   <= {LEN_W{1'b0}};
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      err_r     <= 1'b0;
    end else if (start_ok_s) begin
      len_r     <= len_reg[LEN_W-1:0];
      div_r     <= div_reg[DIV_W-1:0];
      count_r   <= {LEN_W{1'b0}};
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      if (smp_strobe && (count_r != len_r)) begin
        count_r <= count_r + LEN_W'(1);
      end
      if (frame_end) begin
        done_r <= 1'b1;
      end
      if (abort_s) begin
        aborted_r <= 1'b1;
      end
      if (start_bad_s) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef CAPTURE_CTRL_IRQ_EN
  logic irq_pending_r;
  logic unused_s;

  // Interrupt pending: a new set event wins over a clear in the same cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_pending_r <= 1'b0;
    end else if ((frame_end || abort_s) && ctrl_reg[CTRL_IRQ_EN]) begin
      irq_pending_r <= 1'b1;
    end else if (ctrl_reg[CTRL_IRQ_CLR]) begin
      irq_pending_r <= 1'b0;
    end
  end

  assign irq       = irq_pending_r;
  assign irq_bit_s = irq_pending_r;
  assign unused_s  = ^{ctrl_reg[31:4], len_reg[31:LEN_W], div_reg[31:DIV_W]};
`else
  logic unused_s;

  assign irq_bit_s = 1'b0;
  assign unused_s  = ^{ctrl_reg[31:2], len_reg[31:LEN_W], div_reg[31:DIV_W]};
`endif

  assign busy        = run_s;
  assign frame_start = frame_start_r;
  assign cnt_field_s = STAT_CNT_W'(count_r);

  // Status word assembly from registered state.
  always_comb begin
    status_reg                               = 32'd0;
    status_reg[STAT_BUSY]                    = run_s;
    status_reg[STAT_DONE]                    = done_r;
    status_reg[STAT_ABORTED]                 = aborted_r;
    status_reg[STAT_ERR]                     = err_r;
    status_reg[STAT_IRQ]                     = irq_bit_s;
    status_reg[STAT_CNT_LSB +: STAT_CNT_W]   = cnt_field_s;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter LEN_W, default 16, width of the frame-length field and sample counter.
REQ-002 Parameter DIV_W, default 16, width of the strobe-divider field and counter.
REQ-003 ACLK  input  1  single clock; all logic rising-edge.
REQ-004 ARESET  input  1  synchronous, active-high reset.
REQ-005 ctrl_reg  input  32  control word from AXI-Lite register 0: [0] start (level), [1] abort (level), [2] irq_en, [3] irq_clr.
REQ-006 len_reg  input  32  register 1: frame length in samples, low LEN_W bits used.
REQ-007 div_reg  input  32  register 2: ACLK cycles per sample strobe, low DIV_W bits used.
REQ-008 status_reg  output  32  read-back word for register 3: [0] busy, [1] done, [2] aborted, [3] err, [4] irq_pending, [31:16] sample count.
REQ-009 smp_strobe  output  1  one-cycle sample-capture pulse to the microphone front end.
REQ-010 frame_start  output  1  one-cycle pulse on frame begin.
REQ-011 frame_end  output  1  one-cycle pulse coincident with the final smp_strobe.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 irq  output  1  interrupt, present only under CAPTURE_CTRL_IRQ_EN.

Function
REQ-014 Start event SHALL be the rising edge of ctrl_reg[0], detected against a registered copy; a level held high SHALL NOT restart.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE + start with len!=0 and div!=0: latch len and div, clear done/aborted/err, go RUN next cycle, pulse frame_start in that same next cycle.
REQ-017 IDLE + start with len==0 or div==0: set err, stay IDLE, no frame_start.
REQ-018 RUN: divider counts 0..div-1; smp_strobe high for the cycle the counter equals div-1, then the counter wraps to 0.
REQ-019 div==1 SHALL give smp_strobe every RUN cycle.
REQ-020 Sample count SHALL increment on each smp_strobe and saturate at no value other than the latched length.
REQ-021 On the strobe making count equal latched len: assert frame_end in that cycle, go DONE.
REQ-022 DONE: set sticky done, go IDLE next cycle; DONE lasts exactly one cycle.
REQ-023 ctrl_reg[1] high in RUN: go IDLE next cycle, set aborted; abort SHALL take priority over a coincident final strobe (smp_strobe and frame_end suppressed that cycle).
REQ-024 Start edges during RUN or DONE SHALL be ignored, not queued.
REQ-025 len_reg/div_reg changes during RUN SHALL have no effect until the next start.
REQ-026 busy and status[0] SHALL be high exactly in RUN.
REQ-027 status_reg[31:16] SHALL show the current count zero-extended; it SHALL hold after DONE/abort until the next accepted start clears it.

Reset
REQ-028 ARESET high SHALL, at the next edge, force IDLE and clear all counters, sticky bits, the start edge register and irq_pending.
REQ-029 All outputs SHALL be 0 during and after reset until a start event.
REQ-030 Reset asserted mid-frame SHALL abort silently: no frame_end, aborted not set.

Configuration
REQ-031 With CAPTURE_CTRL_IRQ_EN defined: irq_pending is set on entry to DONE or on abort when ctrl_reg[2]=1, cleared when ctrl_reg[3]=1 (set wins on a tie), drives irq and status[4].
REQ-032 Without CAPTURE_CTRL_IRQ_EN: the irq port is absent, status[4] reads 0, and ctrl_reg[2:3] are ignored.

Structure
REQ-033 Package capture_ctrl_pkg SHALL hold the state enum, ctrl bit positions, status bit positions and the count field offset.
REQ-034 Divider and strobe logic SHALL be sub-module capture_strobe_gen (enable, div, strobe out, counter clear on enable low).

Verification
REQ-035 len=4, div=3, ctrl 0->1: frame_start 1 cycle after the edge, strobes every 3 cycles, 4 strobes, frame_end on the 4th, status=0x0004_0002.
REQ-036 len=5, div=1: 5 consecutive strobes, busy high 5 cycles, done set.
REQ-037 len=0, start edge: err set, status=0x0000_0008, no strobe.
REQ-038 len=10, div=2, abort after the 3rd strobe: IDLE next cycle, status[2]=1, count=3, no frame_end.
REQ-039 ctrl[0] held high after DONE plus a second edge during RUN: exactly one frame produced.
REQ-040 IRQ_EN, irq_en=1, len=2, div=2: irq rises on DONE entry, falls the cycle after ctrl[3]=1; ARESET mid-frame clears all status.
